serial_pattern_gen: RTL and testbench

- Upstream stimulus source for the serial sequence-detector stage; drives its `x` input one bit per bit-period, synchronous to the same `cp`.
- Holds a switch-loaded pattern of up to WIDTH bits and shifts it out MSB-first, either once or repeating.
- Provides busy/done status for LEDs and a bit index for the EGO1 seven-segment display.

---
 rtl/serial_pattern_gen.sv | 141 ++++++++++++++
 tb/tb_serial_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: holds a loaded bit pattern and shifts it out MSB-first
// on x, one bit per BIT_CYCLES clocks, optionally repeating with no gap.
// x is the MSB of the shift register flop, so it is glitch-free.
module serial_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int LW         = $clog2(WIDTH + 1)
) (
  input  logic             cp,
  input  logic             rd,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             start,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_idx
);

  localparam int            TW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_pat, w_pat;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic [LW-1:0]    r_len, w_len;
  logic [TW-1:0]    r_tick, w_tick;
  logic [LW-1:0]    r_idx, w_idx;
  logic             r_xv, w_xv;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [WIDTH-1:0] w_src_pat;

  // Length 0 (also the post-reset value) and oversize lengths mean a full-width pass.
  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    if (l == '0 || l > LEN_MAX) return LEN_MAX;
    return l;
  endfunction

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_sh      = r_sh;
    w_len     = r_len;
    w_tick    = r_tick;
    w_idx     = r_idx;
    w_xv      = r_xv;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_src_pat = load ? pattern : r_pat;
    if (stop) begin
      w_state = IDLE;
      w_sh    = '0;
      w_xv    = 1'b0;
      w_busy  = 1'b0;
      w_idx   = '0;
      w_tick  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            w_pat = pattern;
            w_len = eff_len(len);
          end
          if (start) begin
            w_sh    = w_src_pat;
            w_xv    = 1'b1;
            w_busy  = 1'b1;
            w_idx   = '0;
            w_tick  = '0;
            w_state = RUN;
          end
        end
        RUN: begin
          if (r_tick != TICK_LAST) begin
            w_tick = r_tick + 1'b1;
          end else begin
            w_tick = '0;
            if (r_idx == eff_len(r_len) - 1'b1) begin
              if (repeat_en) begin
                w_sh  = r_pat;
                w_idx = '0;
              end else begin
                w_state = IDLE;
                w_sh    = '0;
                w_xv    = 1'b0;
                w_busy  = 1'b0;
                w_idx   = '0;
                w_done  = 1'b1;
              end
            end else begin
              w_sh  = {r_sh[WIDTH-2:0], 1'b0};
              w_idx = r_idx + 1'b1;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge cp or negedge rd) begin
    if (!rd) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_sh    <= '0;
      r_len   <= '0;
      r_tick  <= '0;
      r_idx   <= '0;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pat   <= w_pat;
      r_sh    <= w_sh;
      r_len   <= w_len;
      r_tick  <= w_tick;
      r_idx   <= w_idx;
      r_xv    <= w_xv;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign x       = r_sh[WIDTH-1];
  assign x_valid = r_xv;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bit_idx = r_idx;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: two instances share stimulus,
// one with BIT_CYCLES=1 (a_*) and one with BIT_CYCLES=3 (b_*).
module tb_serial_pattern_gen;

  logic       cp = 1'b0;
  logic       rd = 1'b0;
  logic       load = 1'b0, start = 1'b0, repeat_en = 1'b0, stop = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] len = 4'd0;

  logic       a_x, a_xv, a_busy, a_done;
  logic [3:0] a_idx;
  logic       b_x, b_xv, b_busy, b_done;
  logic [3:0] b_idx;
  logic [7:0] a_st, b_st;

  int n_pass  = 0;
  int n_total = 0;

  assign a_st = {a_x, a_xv, a_busy, a_done, a_idx};
  assign b_st = {b_x, b_xv, b_busy, b_done, b_idx};

  serial_pattern_gen #(.WIDTH(8), .BIT_CYCLES(1)) dut_a (
    .cp(cp), .rd(rd), .load(load), .pattern(pattern), .len(len),
    .start(start), .repeat_en(repeat_en), .stop(stop),
    .x(a_x), .x_valid(a_xv), .busy(a_busy), .done(a_done), .bit_idx(a_idx)
  );

  serial_pattern_gen #(.WIDTH(8), .BIT_CYCLES(3)) dut_b (
    .cp(cp), .rd(rd), .load(load), .pattern(pattern), .len(len),
    .start(start), .repeat_en(repeat_en), .stop(stop),
    .x(b_x), .x_valid(b_xv), .busy(b_busy), .done(b_done), .bit_idx(b_idx)
  );

  always #5 cp = ~cp;

  // Expected status vector {x, x_valid, busy, done, bit_idx}.
  function automatic logic [7:0] st(input logic xb, input logic v, input logic b,
                                    input logic d, input logic [3:0] idx);
    return {xb, v, b, d, idx};
  endfunction

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (a_st !== 8'h00) $display("FAIL reset_a: got %b want %b", a_st, 8'h00); else n_pass++;
    n_total++; if (b_st !== 8'h00) $display("FAIL reset_b: got %b want %b", b_st, 8'h00); else n_pass++;
    #1 rd = 1'b1;
    step();
  endtask

  task automatic test_full_pattern();
    logic [7:0] p = 8'b1011_0100;
    logic [7:0] e;
    load = 1'b1; pattern = p; len = 4'd0;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = st(p[7-i], 1'b1, 1'b1, 1'b0, 4'(i));
      n_total++; if (a_st !== e) $display("FAIL full_bit%0d: got %b want %b", i, a_st, e); else n_pass++;
      if (i < 7) step();
    end
    step();
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL full_done: got %b want %b", a_st, e); else n_pass++;
    step();
    e = 8'h00;
    n_total++; if (a_st !== e) $display("FAIL full_after: got %b want %b", a_st, e); else n_pass++;
  endtask

  task automatic test_slow_bits();
    logic [7:0] p = 8'hB4;
    logic [7:0] e;
    int busy_cnt = 0;
    stop = 1'b1;
    step();
    stop = 1'b0; load = 1'b1; start = 1'b1; pattern = p; len = 4'd3;
    step();
    load = 1'b0; start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      e = st(p[7 - j/3], 1'b1, 1'b1, 1'b0, 4'(j/3));
      n_total++; if (b_st !== e) $display("FAIL slow_cyc%0d: got %b want %b", j, b_st, e); else n_pass++;
      if (b_busy) busy_cnt++;
      step();
    end
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (b_st !== e) $display("FAIL slow_done: got %b want %b", b_st, e); else n_pass++;
    n_total++; if (busy_cnt !== 9) $display("FAIL slow_busy_cycles: got %0d want 9", busy_cnt); else n_pass++;
  endtask

  task automatic test_repeat();
    logic [7:0] e;
    load = 1'b1; start = 1'b1; pattern = 8'b1100_0000; len = 4'd2; repeat_en = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      e = st(1'b1, 1'b1, 1'b1, 1'b0, 4'(j % 2));
      n_total++; if (a_st !== e) $display("FAIL repeat_cyc%0d: got %b want %b", j, a_st, e); else n_pass++;
      if (j == 2) repeat_en = 1'b0;
      step();
    end
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL repeat_done: got %b want %b", a_st, e); else n_pass++;
  endtask

  task automatic test_stop();
    logic [7:0] e;
    stop = 1'b1;
    step();
    stop = 1'b0; load = 1'b1; start = 1'b1; pattern = 8'hB4; len = 4'd0;
    step();
    load = 1'b0; start = 1'b0;
    repeat (4) step();
    e = st(1'b0, 1'b1, 1'b1, 1'b0, 4'd4);
    n_total++; if (a_st !== e) $display("FAIL stop_before: got %b want %b", a_st, e); else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    e = 8'h00;
    n_total++; if (a_st !== e) $display("FAIL stop_abort: got %b want %b", a_st, e); else n_pass++;
    step();
    n_total++; if (a_st !== e) $display("FAIL stop_no_done: got %b want %b", a_st, e); else n_pass++;
    start = 1'b1;
    step();
    start = 1'b0;
    e = st(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL stop_restart0: got %b want %b", a_st, e); else n_pass++;
    step();
    e = st(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
    n_total++; if (a_st !== e) $display("FAIL stop_restart1: got %b want %b", a_st, e); else n_pass++;
  endtask

  task automatic test_load_in_run();
    logic [7:0] p = 8'hB4;
    logic [7:0] e;
    stop = 1'b1;
    step();
    stop = 1'b0; load = 1'b1; start = 1'b1; pattern = p; len = 4'd0;
    step();
    start = 1'b0; pattern = 8'hFF; len = 4'd2;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        e = st(p[7-i], 1'b1, 1'b1, 1'b0, 4'(i));
        n_total++; if (a_st !== e) $display("FAIL ldrun_p%0d_bit%0d: got %b want %b", pass, i, a_st, e); else n_pass++;
        step();
      end
      e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      n_total++; if (a_st !== e) $display("FAIL ldrun_p%0d_done: got %b want %b", pass, a_st, e); else n_pass++;
      if (pass == 0) begin
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
      end
    end
  endtask

  task automatic test_len_edges();
    logic [7:0] p = 8'h81;
    logic [7:0] e;
    step();
    load = 1'b1; start = 1'b1; pattern = p; len = 4'd12;
    step();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = st(p[7-i], 1'b1, 1'b1, 1'b0, 4'(i));
      n_total++; if (a_st !== e) $display("FAIL clamp_bit%0d: got %b want %b", i, a_st, e); else n_pass++;
      step();
    end
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL clamp_done: got %b want %b", a_st, e); else n_pass++;
    load = 1'b1; start = 1'b1; pattern = 8'h80; len = 4'd1;
    step();
    load = 1'b0; start = 1'b0;
    e = st(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL len1_bit: got %b want %b", a_st, e); else n_pass++;
    step();
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL len1_done: got %b want %b", a_st, e); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    step();
    load = 1'b1; start = 1'b1; pattern = 8'hB4; len = 4'd0;
    step();
    load = 1'b0; start = 1'b0;
    step();
    #2 rd = 1'b0;
    #1;
    n_total++; if (a_st !== 8'h00) $display("FAIL arst_a: got %b want %b", a_st, 8'h00); else n_pass++;
    n_total++; if (b_st !== 8'h00) $display("FAIL arst_b: got %b want %b", b_st, 8'h00); else n_pass++;
    #1 rd = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = st(1'b0, 1'b1, 1'b1, 1'b0, 4'(i));
      n_total++; if (a_st !== e) $display("FAIL arst_zero_bit%0d: got %b want %b", i, a_st, e); else n_pass++;
      step();
    end
    e = st(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    n_total++; if (a_st !== e) $display("FAIL arst_zero_done: got %b want %b", a_st, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_pattern();
    test_slow_bits();
    test_repeat();
    test_stop();
    test_load_in_run();
    test_len_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
